// File: rtl/mc_controller.sv
// mc_controller: multi-cycle sequencer for an RV32I datapath.
// It drives the instruction/data memory handshakes and gates the write strobes
// so that architectural state only changes in the right phase. It also detects
// illegal opcodes and memory-ack timeouts, both of which halt with a sticky err.
// Optional retired-instruction counter: define MC_INSTRET_EN to build it;
// otherwise instret is tied to zero.
module mc_controller #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic [6:0]  opcode,
   input  logic        imem_ack,
   input  logic        dmem_ack,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        ir_en,
   output logic        pc_en,
   output logic        reg_wr_en,
   output logic        mem_wr_en,
   output logic [2:0]  state,
   output logic        err,
   output logic [31:0] instret
);

   localparam int unsigned CNT_W    = 8;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_UNUSED = 3'd7
   } state_t;

   state_t cur_state;
   state_t nxt_state;

   logic [CNT_W-1:0] wait_cnt;
   logic             is_load;
   logic             is_store;
   logic             is_branch;
   logic             is_legal;
   logic             wait_expired;
   logic             set_err;

   // Opcode classification taken straight from the instruction register
   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   assign is_branch = (opcode == OP_BRANCH);
   assign is_legal  = (opcode == OP_R)      || (opcode == OP_I)     ||
                      (opcode == OP_LOAD)   || (opcode == OP_STORE) ||
                      (opcode == OP_BRANCH) || (opcode == OP_LUI)   ||
                      (opcode == OP_AUIPC)  || (opcode == OP_JAL)   ||
                      (opcode == OP_JALR);

   // This request cycle is the last one allowed without an ack
   assign wait_expired = (wait_cnt == WAIT_LAST);
   assign set_err      = (nxt_state == S_HALT) && (cur_state != S_HALT);
   assign state        = cur_state;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cur_state <= S_IDLE;
      else     cur_state <= nxt_state;
   end

   // Next-state decode
   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         S_IDLE: begin
            if (run) nxt_state = S_FETCH;
         end
         S_FETCH: begin
            if (imem_ack)          nxt_state = S_DECODE;
            else if (wait_expired) nxt_state = S_HALT;
         end
         S_DECODE: begin
            nxt_state = is_legal ? S_EXEC : S_HALT;
         end
         S_EXEC: begin
            if (is_load || is_store) nxt_state = S_MEM;
            else if (is_branch)      nxt_state = run ? S_FETCH : S_IDLE;
            else                     nxt_state = S_WB;
         end
         S_MEM: begin
            if (dmem_ack) begin
               if (is_store) nxt_state = run ? S_FETCH : S_IDLE;
               else          nxt_state = S_WB;
            end else if (wait_expired) begin
               nxt_state = S_HALT;
            end
         end
         S_WB: begin
            nxt_state = run ? S_FETCH : S_IDLE;
         end
         default: nxt_state = S_HALT;
      endcase
   end

   // Strobe decode from state and the current-cycle acks
   always_comb begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      ir_en     = 1'b0;
      pc_en     = 1'b0;
      reg_wr_en = 1'b0;
      mem_wr_en = 1'b0;
      case (cur_state)
         S_FETCH: begin
            imem_req = 1'b1;
            ir_en    = imem_ack;
         end
         S_EXEC: begin
            pc_en = is_branch;
         end
         S_MEM: begin
            dmem_req  = 1'b1;
            mem_wr_en = is_store;
            pc_en     = is_store && dmem_ack;
         end
         S_WB: begin
            reg_wr_en = 1'b1;
            pc_en     = 1'b1;
         end
         default: ;
      endcase
   end

   // Wait counter: cleared on entering a request state, counts unacked request cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if ((nxt_state == S_FETCH && cur_state != S_FETCH) ||
                   (nxt_state == S_MEM   && cur_state != S_MEM)) begin
         wait_cnt <= '0;
      end else if ((imem_req && !imem_ack) || (dmem_req && !dmem_ack)) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

   // Sticky error flag, set on any transition into HALT
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          err <= 1'b0;
      else if (set_err) err <= 1'b1;
   end

`ifdef MC_INSTRET_EN
   logic [31:0] instret_q;

   // Retired-instruction counter, wraps naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        instret_q <= 32'h0;
      else if (pc_en) instret_q <= instret_q + 32'd1;
   end

   assign instret = instret_q;
`else
   assign instret = 32'h0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller (TIMEOUT=4). Honours MC_INSTRET_EN.
module tb_mc_controller;

   logic        clk;
   logic        rst;
   logic        run;
   logic [6:0]  opcode;
   logic        imem_ack;
   logic        dmem_ack;
   logic        imem_req;
   logic        dmem_req;
   logic        ir_en;
   logic        pc_en;
   logic        reg_wr_en;
   logic        mem_wr_en;
   logic [2:0]  state;
   logic        err;
   logic [31:0] instret;

   int total = 0;
   int bad   = 0;

`ifdef MC_INSTRET_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   mc_controller #(.TIMEOUT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .opcode    (opcode),
      .imem_ack  (imem_ack),
      .dmem_ack  (dmem_ack),
      .imem_req  (imem_req),
      .dmem_req  (dmem_req),
      .ir_en     (ir_en),
      .pc_en     (pc_en),
      .reg_wr_en (reg_wr_en),
      .mem_wr_en (mem_wr_en),
      .state     (state),
      .err       (err),
      .instret   (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int both_total = 0;

   // Run one instruction from a FETCH cycle; ack after iw / dw wait cycles
   task automatic do_instr(input logic [6:0] op, input int iw, input int dw,
                           output logic [31:0] seq, output int wb_n, output int mw_n,
                           output int pc_n, output int dq_n);
      int  fc;
      int  mc;
      bit  done;
      fc = 0; mc = 0; done = 1'b0;
      seq = 32'h0; wb_n = 0; mw_n = 0; pc_n = 0; dq_n = 0;
      opcode = op;
      for (int i = 0; i < 40; i++) begin
         imem_ack = (state == 3'd1) && (fc == iw);
         dmem_ack = (state == 3'd4) && (mc == dw);
         #1;
         seq = {seq[27:0], 1'b0, state};
         if (reg_wr_en) wb_n++;
         if (mem_wr_en) mw_n++;
         if (dmem_req)  dq_n++;
         if (pc_en)     pc_n++;
         if (imem_req && dmem_req) both_total++;
         if (state == 3'd1) fc++;
         if (state == 3'd4) mc++;
         if (pc_en) begin
            done = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!done) check("retire_bound", 32'(done), 32'd1);
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
   endtask

   logic [31:0] seq;
   int wb_n, mw_n, pc_n, dq_n;

   initial begin
      rst = 1'b1; run = 1'b0; opcode = 7'h0; imem_ack = 1'b0; dmem_ack = 1'b0;
      step();
      check("rst_state",   32'(state), 32'd0);
      check("rst_err",     32'(err), 32'd0);
      check("rst_imem",    32'(imem_req), 32'd0);
      check("rst_pc_en",   32'(pc_en), 32'd0);
      check("rst_instret", instret, 32'd0);
      rst = 1'b0;
      run = 1'b1;
      check("idle_hold", 32'(state), 32'd0);
      step();
      check("fetch_entry", 32'(state), 32'd1);

      do_instr(OP_R, 0, 0, seq, wb_n, mw_n, pc_n, dq_n);
      check("r_seq",  seq, 32'h1235);
      check("r_wb",   32'(wb_n), 32'd1);
      check("r_pc",   32'(pc_n), 32'd1);
      check("r_mw",   32'(mw_n), 32'd0);
      check("r_instret", instret, CNT_ON ? 32'd1 : 32'd0);
      check("r_next", 32'(state), 32'd1);

      do_instr(OP_LOAD, 0, 2, seq, wb_n, mw_n, pc_n, dq_n);
      check("ld_seq", seq, 32'h1234445);
      check("ld_dq",  32'(dq_n), 32'd3);
      check("ld_wb",  32'(wb_n), 32'd1);
      check("ld_pc",  32'(pc_n), 32'd1);

      do_instr(OP_STORE, 0, 0, seq, wb_n, mw_n, pc_n, dq_n);
      check("st_seq", seq, 32'h1234);
      check("st_mw",  32'(mw_n), 32'd1);
      check("st_wb",  32'(wb_n), 32'd0);
      check("st_pc",  32'(pc_n), 32'd1);

      do_instr(OP_BRANCH, 0, 0, seq, wb_n, mw_n, pc_n, dq_n);
      check("br_seq", seq, 32'h123);
      check("br_wb",  32'(wb_n), 32'd0);
      check("br_pc",  32'(pc_n), 32'd1);

      do_instr(OP_JAL, 3, 0, seq, wb_n, mw_n, pc_n, dq_n);
      check("late_ack_seq", seq, 32'h1111235);
      check("late_ack_err", 32'(err), 32'd0);
      check("late_ack_pc",  32'(pc_n), 32'd1);
      check("req_overlap",  32'(both_total), 32'd0);
      check("instret5", instret, CNT_ON ? 32'd5 : 32'd0);

      // Asynchronous reset in the middle of a MEM wait
      opcode = OP_LOAD;
      imem_ack = 1'b1;
      step();
      imem_ack = 1'b0;
      check("mid_dec", 32'(state), 32'd2);
      step();
      step();
      check("mid_mem",   32'(state), 32'd4);
      check("mid_dreq",  32'(dmem_req), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_state",   32'(state), 32'd0);
      check("arst_err",     32'(err), 32'd0);
      check("arst_dreq",    32'(dmem_req), 32'd0);
      check("arst_instret", instret, 32'd0);
      step();
      rst = 1'b0;

      // Fetch timeout: no imem_ack for 4 request cycles
      step();
      for (int i = 0; i < 4; i++) begin
         check("to_fetch", 32'(state), 32'd1);
         check("to_ireq",  32'(imem_req), 32'd1);
         step();
      end
      check("to_halt", 32'(state), 32'd6);
      check("to_err",  32'(err), 32'd1);
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("halt_state", 32'(state), 32'd6);
         check("halt_err",   32'(err), 32'd1);
         check("halt_ireq",  32'(imem_req), 32'd0);
         check("halt_pc",    32'(pc_en), 32'd0);
      end
      rst = 1'b1;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      #1;
      check("halt_rst_state", 32'(state), 32'd0);
      check("halt_rst_err",   32'(err), 32'd0);
      step();
      rst = 1'b0;

      // Illegal opcode halts from DECODE
      step();
      check("ill_fetch", 32'(state), 32'd1);
      opcode = 7'b0000000;
      imem_ack = 1'b1;
      #1;
      check("ill_ir_en", 32'(ir_en), 32'd1);
      step();
      imem_ack = 1'b0;
      check("ill_dec", 32'(state), 32'd2);
      check("ill_dec_err", 32'(err), 32'd0);
      step();
      check("ill_halt", 32'(state), 32'd6);
      check("ill_err",  32'(err), 32'd1);

      // Counter wrap
      rst = 1'b1;
      run = 1'b0;
      step();
      rst = 1'b0;
`ifdef MC_INSTRET_EN
      force dut.instret_q = 32'hFFFF_FFFF;
      #1;
      release dut.instret_q;
      #1;
      check("wrap_pre", instret, 32'hFFFF_FFFF);
`endif
      run = 1'b1;
      step();
      do_instr(OP_BRANCH, 0, 0, seq, wb_n, mw_n, pc_n, dq_n);
      check("wrap_seq", seq, 32'h123);
      check("wrap_instret", instret, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
